// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: FSM state encoding,
// keypad code map and a constant-width helper.
package vending_pkg;

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned ITEM_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam logic [KEY_W-1:0] KEY_COIN0     = 4'h1;
  localparam logic [KEY_W-1:0] KEY_COIN1     = 4'h2;
  localparam logic [KEY_W-1:0] KEY_COIN2     = 4'h3;
  localparam logic [KEY_W-1:0] KEY_ITEM_BASE = 4'h4;
  localparam logic [KEY_W-1:0] KEY_CANCEL    = 4'hE;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// Ports:
//   clk, reset (async, active-low)
//   start  - load bin and (re)start a conversion; aborts any conversion in flight
//   bin    - binary value sampled on start
//   bcd    - last completed result, digit 0 in LSBs; held during conversion
//   valid  - high when bcd reflects the last started value
module bin2bcd_seq
  import vending_pkg::*;
#(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = (clog2(IN_W) < 1) ? 1 : clog2(IN_W);

  logic [IN_W-1:0]  sh_bin;
  logic [BCD_W-1:0] sh_bcd;
  logic [CNT_W-1:0] cnt;
  logic             running;

  logic [BCD_W-1:0] adj_c;
  logic [BCD_W-1:0] bcd_shift_c;
  logic [IN_W-1:0]  bin_shift_c;

  // Add-3 on every digit >= 5, then shift the next binary bit into digit 0.
  always_comb begin
    adj_c = sh_bcd;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (sh_bcd[4*d +: 4] >= 4'd5) adj_c[4*d +: 4] = sh_bcd[4*d +: 4] + 4'd3;
    end
    {bcd_shift_c, bin_shift_c} = {adj_c, sh_bin} << 1;
  end

  // Shift engine; the final shift writes the result straight to bcd.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_bin  <= '0;
      sh_bcd  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      bcd     <= '0;
      valid   <= 1'b1;
    end else if (start) begin
      sh_bin  <= bin;
      sh_bcd  <= '0;
      cnt     <= '0;
      running <= 1'b1;
      valid   <= 1'b0;
    end else if (running) begin
      sh_bin <= bin_shift_c;
      sh_bcd <= bcd_shift_c;
      cnt    <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(IN_W - 1)) begin
        bcd     <= bcd_shift_c;
        valid   <= 1'b1;
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vending_ctrl_fsm.sv
// Vending controller: credit accumulation, vend, change return, per-item stock
// and BCD credit display.
// Ports:
//   clk, reset (async, active-low)
//   key_valid/key_code - debounced key event (coins, item selects, cancel)
//   credit, bcd, bcd_valid - current credit in binary and BCD
//   vend_pulse/vend_item - dispense strobe and item index
//   change_pulse, reject_pulse, deny_pulse - one-cycle event strobes
//   sold_out - per-item empty flags; busy - high in VEND or CHANGE
module vending_ctrl_fsm
  import vending_pkg::*;
#(
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned PRICE       = 50,
  parameter int unsigned COIN0_VAL   = 5,
  parameter int unsigned COIN1_VAL   = 10,
  parameter int unsigned COIN2_VAL   = 25,
  parameter int unsigned CHANGE_UNIT = 5,
  parameter int unsigned MAX_CREDIT  = 200,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned STOCK_INIT  = 3,
  parameter int unsigned NUM_DIGITS  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [KEY_W-1:0]        key_code,
  output logic [CREDIT_W-1:0]     credit,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    bcd_valid,
  output logic                    vend_pulse,
  output logic [ITEM_W-1:0]       vend_item,
  output logic                    change_pulse,
  output logic                    reject_pulse,
  output logic                    deny_pulse,
  output logic [NUM_ITEMS-1:0]    sold_out,
  output logic                    busy
);

  localparam int unsigned STOCK_RAW = clog2(STOCK_INIT + 1);
  localparam int unsigned STOCK_W   = (STOCK_RAW < 1) ? 1 : STOCK_RAW;
  localparam int unsigned SUM_W     = CREDIT_W + 1;
  localparam int unsigned KEY_X     = KEY_W + 1;
  localparam logic [KEY_X-1:0] ITEM_END = KEY_X'(KEY_ITEM_BASE) + KEY_X'(NUM_ITEMS);

  state_t               state, state_n;
  logic [CREDIT_W-1:0]  credit_n;
  logic [STOCK_W-1:0]   stock   [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_n [NUM_ITEMS];
  logic                 vend_n, change_n, reject_n, deny_n, busy_n;
  logic [ITEM_W-1:0]    vend_item_n;
  logic [NUM_ITEMS-1:0] sold_out_n;
  logic                 bcd_start, bcd_start_n;

  logic                 is_coin_c, is_item_c, is_cancel_c, item_stocked_c;
  logic [CREDIT_W-1:0]  coin_val_c;
  logic [SUM_W-1:0]     coin_sum_c;
  logic [ITEM_W-1:0]    item_idx_c;

  // Key decode and selected-item stock lookup.
  always_comb begin
    is_coin_c  = 1'b1;
    coin_val_c = '0;
    case (key_code)
      KEY_COIN0: coin_val_c = CREDIT_W'(COIN0_VAL);
      KEY_COIN1: coin_val_c = CREDIT_W'(COIN1_VAL);
      KEY_COIN2: coin_val_c = CREDIT_W'(COIN2_VAL);
      default:   is_coin_c  = 1'b0;
    endcase
    coin_sum_c  = SUM_W'(credit) + SUM_W'(coin_val_c);
    is_item_c   = (key_code >= KEY_ITEM_BASE) && ({1'b0, key_code} < ITEM_END);
    item_idx_c  = ITEM_W'(key_code - KEY_ITEM_BASE);
    is_cancel_c = (key_code == KEY_CANCEL);
    item_stocked_c = 1'b0;
    for (int i = 0; i < int'(NUM_ITEMS); i++) begin
      if (ITEM_W'(i) == item_idx_c) item_stocked_c = (stock[i] != '0);
    end
  end

  // Next-state, credit, stock and pulse logic.
  always_comb begin
    state_n     = state;
    credit_n    = credit;
    stock_n     = stock;
    vend_n      = 1'b0;
    vend_item_n = '0;
    reject_n    = 1'b0;
    deny_n      = 1'b0;

    case (state)
      IDLE, CREDIT: begin
        if (key_valid) begin
          if (is_coin_c) begin
            if (coin_sum_c <= SUM_W'(MAX_CREDIT)) begin
              credit_n = coin_sum_c[CREDIT_W-1:0];
              state_n  = CREDIT;
            end else begin
              reject_n = 1'b1;
            end
          end else if (is_item_c) begin
            if (state == CREDIT && credit >= CREDIT_W'(PRICE) && item_stocked_c) begin
              state_n     = VEND;
              vend_n      = 1'b1;
              vend_item_n = item_idx_c;
            end else begin
              deny_n = 1'b1;
            end
          end else if (is_cancel_c && state == CREDIT) begin
            state_n = CHANGE;
          end
        end
      end
      VEND: begin
        // vend_item still holds the selected index during this cycle.
        credit_n = credit - CREDIT_W'(PRICE);
        for (int i = 0; i < int'(NUM_ITEMS); i++) begin
          if (ITEM_W'(i) == vend_item && stock[i] != '0) stock_n[i] = stock[i] - STOCK_W'(1);
        end
        state_n = (credit_n != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (credit <= CREDIT_W'(CHANGE_UNIT)) begin
          credit_n = '0;
          state_n  = IDLE;
        end else begin
          credit_n = credit - CREDIT_W'(CHANGE_UNIT);
        end
      end
      default: state_n = IDLE;
    endcase

    change_n    = (state_n == CHANGE);
    busy_n      = (state_n == VEND) || (state_n == CHANGE);
    bcd_start_n = (credit_n != credit);
    for (int i = 0; i < int'(NUM_ITEMS); i++) sold_out_n[i] = (stock[i] == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      credit       <= '0;
      for (int i = 0; i < int'(NUM_ITEMS); i++) stock[i] <= STOCK_W'(STOCK_INIT);
      vend_pulse   <= 1'b0;
      vend_item    <= '0;
      change_pulse <= 1'b0;
      reject_pulse <= 1'b0;
      deny_pulse   <= 1'b0;
      sold_out     <= '0;
      busy         <= 1'b0;
      bcd_start    <= 1'b0;
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      stock        <= stock_n;
      vend_pulse   <= vend_n;
      vend_item    <= vend_item_n;
      change_pulse <= change_n;
      reject_pulse <= reject_n;
      deny_pulse   <= deny_n;
      sold_out     <= sold_out_n;
      busy         <= busy_n;
      bcd_start    <= bcd_start_n;
    end
  end

  bin2bcd_seq #(
    .IN_W   (CREDIT_W),
    .DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start),
    .bin   (credit),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

endmodule

// File: tb/tb_vending_ctrl_fsm.sv
// Directed testbench for vending_ctrl_fsm with default parameters.
module tb_vending_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [7:0]  credit;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        vend_pulse;
  logic [2:0]  vend_item;
  logic        change_pulse;
  logic        reject_pulse;
  logic        deny_pulse;
  logic [3:0]  sold_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vending_ctrl_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .credit       (credit),
    .bcd          (bcd),
    .bcd_valid    (bcd_valid),
    .vend_pulse   (vend_pulse),
    .vend_item    (vend_item),
    .change_pulse (change_pulse),
    .reject_pulse (reject_pulse),
    .deny_pulse   (deny_pulse),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle key strobe; returns on the negedge after the sampling edge.
  task automatic key(input logic [3:0] code);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  // Counts change pulses from the current cycle until busy drops.
  task automatic drain(input int bound, output int pulses);
    bit done;
    pulses = 0;
    done   = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (change_pulse) pulses++;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL drain_timeout got busy=%0b want 0 within %0d cycles", busy, bound); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL rst_credit got %0d want 0", credit); end
    checks++; if (bcd !== 12'h000 || bcd_valid !== 1'b1) begin errors++; $display("FAIL rst_bcd got %0h/%0b want 000/1", bcd, bcd_valid); end
    checks++; if ({vend_pulse, change_pulse, reject_pulse, deny_pulse, busy, sold_out} !== 9'd0) begin errors++; $display("FAIL rst_outs got %0h want 0", {vend_pulse, change_pulse, reject_pulse, deny_pulse, busy, sold_out}); end
    @(negedge clk);
    reset = 1'b1;
    step(1);
    // Mid-traffic: reset during the VEND cycle.
    key(4'h3); key(4'h3); key(4'h4);
    checks++; if (vend_pulse !== 1'b1 || vend_item !== 3'd0) begin errors++; $display("FAIL pre_rst_vend got %0b/%0d want 1/0", vend_pulse, vend_item); end
    #2 reset = 1'b0;
    #1;
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL midrst_credit got %0d want 0", credit); end
    checks++; if (bcd !== 12'h000 || bcd_valid !== 1'b1) begin errors++; $display("FAIL midrst_bcd got %0h/%0b want 000/1", bcd, bcd_valid); end
    checks++; if ({vend_pulse, vend_item, change_pulse, reject_pulse, deny_pulse, busy, sold_out} !== 12'd0) begin errors++; $display("FAIL midrst_outs got %0h want 0", {vend_pulse, vend_item, change_pulse, reject_pulse, deny_pulse, busy, sold_out}); end
    @(negedge clk);
    reset = 1'b1;
    step(2);
    for (int i = 0; i < 4; i++) begin
      checks++; if (dut.stock[i] !== 2'd3) begin errors++; $display("FAIL stock_init[%0d] got %0d want 3", i, dut.stock[i]); end
    end
    checks++; if (credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL post_rst got credit=%0d busy=%0b want 0/0", credit, busy); end
  endtask

  task automatic test_vend_change();
    int n;
    key(4'h3); key(4'h3); key(4'h2);
    checks++; if (credit !== 8'd60) begin errors++; $display("FAIL vc_credit got %0d want 60", credit); end
    step(8);
    checks++; if (bcd_valid !== 1'b0 || bcd !== 12'h000) begin errors++; $display("FAIL vc_bcd_early got %0h/%0b want 000/0", bcd, bcd_valid); end
    step(1);
    checks++; if (bcd !== 12'h060 || bcd_valid !== 1'b1) begin errors++; $display("FAIL vc_bcd got %0h/%0b want 060/1", bcd, bcd_valid); end
    key(4'h6);
    checks++; if (vend_pulse !== 1'b1 || vend_item !== 3'd2 || busy !== 1'b1 || credit !== 8'd60) begin errors++; $display("FAIL vc_vend got p=%0b i=%0d b=%0b c=%0d want 1/2/1/60", vend_pulse, vend_item, busy, credit); end
    step(1);
    checks++; if (vend_pulse !== 1'b0 || change_pulse !== 1'b1 || credit !== 8'd10) begin errors++; $display("FAIL vc_after_vend got v=%0b ch=%0b c=%0d want 0/1/10", vend_pulse, change_pulse, credit); end
    drain(20, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL vc_change_cnt got %0d want 2", n); end
    checks++; if (credit !== 8'd0 || dut.state !== 2'd0) begin errors++; $display("FAIL vc_end got c=%0d st=%0d want 0/0", credit, dut.state); end
    checks++; if (dut.stock[2] !== 2'd2) begin errors++; $display("FAIL vc_stock2 got %0d want 2", dut.stock[2]); end
  endtask

  task automatic test_credit_limit();
    int rej, n;
    rej = 0;
    for (int k = 0; k < 8; k++) begin
      key(4'h3);
      if (reject_pulse) rej++;
    end
    checks++; if (credit !== 8'd200 || rej !== 0) begin errors++; $display("FAIL cl_full got c=%0d rej=%0d want 200/0", credit, rej); end
    step(9);
    checks++; if (bcd !== 12'h200 || bcd_valid !== 1'b1) begin errors++; $display("FAIL cl_bcd got %0h/%0b want 200/1", bcd, bcd_valid); end
    key(4'h1);
    checks++; if (reject_pulse !== 1'b1 || credit !== 8'd200) begin errors++; $display("FAIL cl_reject got r=%0b c=%0d want 1/200", reject_pulse, credit); end
    step(1);
    checks++; if (reject_pulse !== 1'b0) begin errors++; $display("FAIL cl_reject_len got %0b want 0", reject_pulse); end
    key(4'hE);
    drain(100, n);
    checks++; if (n !== 40 || credit !== 8'd0) begin errors++; $display("FAIL cl_refund got n=%0d c=%0d want 40/0", n, credit); end
  endtask

  task automatic test_insufficient();
    int n;
    key(4'h5);
    checks++; if (deny_pulse !== 1'b1 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL in_idle_sel got d=%0b c=%0d want 1/0", deny_pulse, credit); end
    key(4'h3);
    key(4'h4);
    checks++; if (deny_pulse !== 1'b1 || vend_pulse !== 1'b0 || credit !== 8'd25 || busy !== 1'b0) begin errors++; $display("FAIL in_deny got d=%0b v=%0b c=%0d want 1/0/25", deny_pulse, vend_pulse, credit); end
    key(4'hF);
    checks++; if ({deny_pulse, reject_pulse, vend_pulse, change_pulse} !== 4'd0 || credit !== 8'd25) begin errors++; $display("FAIL in_keyF got %0b c=%0d want 0000/25", {deny_pulse, reject_pulse, vend_pulse, change_pulse}, credit); end
    key(4'h8);
    checks++; if ({deny_pulse, vend_pulse} !== 2'd0 || credit !== 8'd25) begin errors++; $display("FAIL in_key8 got %0b c=%0d want 00/25", {deny_pulse, vend_pulse}, credit); end
    key(4'hE);
    drain(20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL in_refund got %0d want 5", n); end
  endtask

  task automatic test_sold_out();
    int n;
    for (int k = 0; k < 3; k++) begin
      key(4'h3); key(4'h3); key(4'h4);
      checks++; if (vend_pulse !== 1'b1 || vend_item !== 3'd0) begin errors++; $display("FAIL so_vend%0d got %0b/%0d want 1/0", k, vend_pulse, vend_item); end
      drain(10, n);
      checks++; if (n !== 0 || credit !== 8'd0) begin errors++; $display("FAIL so_nochange%0d got n=%0d c=%0d want 0/0", k, n, credit); end
    end
    checks++; if (sold_out !== 4'b0000) begin errors++; $display("FAIL so_lag got %0b want 0000", sold_out); end
    step(1);
    checks++; if (sold_out !== 4'b0001) begin errors++; $display("FAIL so_flag got %0b want 0001", sold_out); end
    key(4'h3); key(4'h3); key(4'h4);
    checks++; if (deny_pulse !== 1'b1 || vend_pulse !== 1'b0 || credit !== 8'd50) begin errors++; $display("FAIL so_deny got d=%0b v=%0b c=%0d want 1/0/50", deny_pulse, vend_pulse, credit); end
    key(4'hE);
    drain(30, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL so_refund got %0d want 10", n); end
  endtask

  task automatic test_busy_reset();
    int n, ev;
    bit done;
    key(4'h3); key(4'h2);
    checks++; if (credit !== 8'd35) begin errors++; $display("FAIL br_credit got %0d want 35", credit); end
    key(4'hE);
    n = 0; ev = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (change_pulse) n++;
      if (reject_pulse || deny_pulse || vend_pulse) ev++;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (c == 1) begin key_valid = 1'b1; key_code = 4'h3; end
      if (c == 2) begin key_valid = 1'b0; key_code = 4'h0; end
      @(negedge clk);
    end
    key_valid = 1'b0;
    checks++; if (done !== 1'b1 || n !== 7 || ev !== 0 || credit !== 8'd0) begin errors++; $display("FAIL br_busy_key got done=%0b n=%0d ev=%0d c=%0d want 1/7/0/0", done, n, ev, credit); end
    // Repeat and reset after the third pulse.
    key(4'h3); key(4'h2); key(4'hE);
    n = (change_pulse === 1'b1) ? 1 : 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      @(negedge clk);
      if (change_pulse) n++;
    end
    checks++; if (n !== 3 || credit !== 8'd25) begin errors++; $display("FAIL br_third got n=%0d c=%0d want 3/25", n, credit); end
    #2 reset = 1'b0;
    #1;
    checks++; if (change_pulse !== 1'b0 || credit !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL br_rst got ch=%0b c=%0d b=%0b want 0/0/0", change_pulse, credit, busy); end
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (change_pulse) n++;
    end
    checks++; if (n !== 0 || credit !== 8'd0 || bcd_valid !== 1'b1 || bcd !== 12'h000) begin errors++; $display("FAIL br_after got n=%0d c=%0d bcd=%0h/%0b want 0/0/000/1", n, credit, bcd, bcd_valid); end
  endtask

  initial begin
    test_reset();
    test_vend_change();
    test_credit_limit();
    test_insufficient();
    test_sold_out();
    test_busy_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vending_ctrl_fsm.md
Name: vending_ctrl_fsm

Overview:
- Parametrised successor to the fixed keypad→debounce→counter→BCD vending datapath.
- Consumes debounced key events (code + valid strobe) from the existing keypad/debounce front end.
- Runs a credit/vend/change state machine with per-item stock tracking and coin rejection.
- Presents credit as NUM_DIGITS BCD digits, produced by a sequential converter, for the existing seven-segment decoders.

Parameters:
- NUM_ITEMS, 4, number of selectable items (1..8).
- PRICE, 50, price of every item in credit units.
- COIN0_VAL, 5, credit value of key code 0x1.
- COIN1_VAL, 10, credit value of key code 0x2.
- COIN2_VAL, 25, credit value of key code 0x3.
- CHANGE_UNIT, 5, value of one change_pulse. PRICE, all COINn_VAL and MAX_CREDIT must be multiples of it.
- MAX_CREDIT, 200, maximum credit accepted.
- CREDIT_W, 8, credit register width. Must satisfy 2^CREDIT_W > MAX_CREDIT.
- STOCK_INIT, 3, units per item after reset.
- NUM_DIGITS, 3, BCD digits shown. Must satisfy 10^NUM_DIGITS > MAX_CREDIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe: key_code is valid this cycle.
- key_code  in  4  key code: 0x1-0x3 coins; 0x4..0x4+NUM_ITEMS-1 item select; 0xE cancel; all others ignored.
- credit  out  CREDIT_W  current credit, binary.
- bcd  out  4*NUM_DIGITS  credit as BCD, digit 0 in LSBs.
- bcd_valid  out  1  high when bcd matches credit.
- vend_pulse  out  1  one-cycle dispense strobe.
- vend_item  out  3  item index; valid while vend_pulse is high.
- change_pulse  out  1  one pulse per CHANGE_UNIT returned.
- reject_pulse  out  1  coin refused (would exceed MAX_CREDIT).
- deny_pulse  out  1  selection refused (insufficient credit, sold out, or IDLE).
- sold_out  out  NUM_ITEMS  bit i high when stock[i]==0.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, credit=0, every stock=STOCK_INIT.
  - All pulses, vend_item, sold_out and busy = 0.
  - bcd=0, bcd_valid=1.
  - Reset mid-operation aborts immediately; no pending vend or change survives.
- States: IDLE (credit==0), CREDIT, VEND, CHANGE.
- All outputs are registered. A key sampled at edge n produces its effect (credit, pulses, state) visible in cycle n+1.
- Coin in IDLE or CREDIT:
  - If credit+value <= MAX_CREDIT: credit+=value, go to CREDIT.
  - Otherwise: reject_pulse for 1 cycle, credit unchanged.
  - A coin that lands exactly on MAX_CREDIT is accepted.
- Select item i in CREDIT:
  - If credit>=PRICE and stock[i]>0: go to VEND.
  - Otherwise: deny_pulse for 1 cycle, state and credit unchanged.
  - i>=NUM_ITEMS: ignored, no pulse.
  - Select in IDLE: deny_pulse.
- VEND lasts exactly 1 cycle:
  - vend_pulse=1, vend_item=i.
  - At the end of the cycle: credit-=PRICE, stock[i]-=1.
  - Next state: CHANGE if the remaining credit >0, else IDLE.
- Cancel:
  - In CREDIT: go to CHANGE.
  - In IDLE: ignored.
- CHANGE:
  - Every cycle: change_pulse=1, credit-=CHANGE_UNIT.
  - On the cycle credit reaches 0, return to IDLE.
  - Total pulses = entry credit / CHANGE_UNIT.
- While busy, key_valid is ignored (not queued) and produces no pulse.
- Codes 0x0, 0xD, 0xF, and 0x4+NUM_ITEMS..0xC are ignored in every state.
- sold_out[i] is registered; it updates the cycle after stock[i] reaches 0.
- Stock counters saturate at 0; no underflow is possible because select is checked first.
- BCD conversion (sequential double-dabble):
  - Starts on any credit change. bcd_valid drops the next cycle.
  - bcd holds its old value until conversion completes, CREDIT_W+1 cycles after the credit update; bcd and bcd_valid then update together.
  - A credit change mid-conversion aborts it and restarts with the new value.
  - During CHANGE, bcd_valid therefore stays low until credit settles.

Decomposition:
- Shared package vending_pkg:
  - state enum (IDLE, CREDIT, VEND, CHANGE).
  - Key-code constants KEY_COIN0..2, KEY_ITEM_BASE, KEY_CANCEL.
  - Function clog2 for the stock counter width clog2(STOCK_INIT+1).
- Sub-module bin2bcd_seq (params IN_W, DIGITS):
  - ports clk, reset, start, bin, bcd, valid.
  - Iterative shift-add-3, one bit per cycle, with restart on start.
- Top module holds the FSM, credit register, stock array and pulse registers.

Test Plan:
All scenarios use default parameters.
1. Reset:
   - Drive reset low mid-traffic → credit=0, bcd=0x000, bcd_valid=1, sold_out=0000, all pulses 0.
   - Release reset and check that all 4 stocks equal 3.
2. Vend with change:
   - Keys 0x3,0x3,0x2 → credit=60, and bcd=0x060 after 9 cycles.
   - Key 0x6 → one vend_pulse with vend_item=2, then exactly 2 change_pulse cycles, credit=0, state IDLE.
3. Credit limit:
   - 8× key 0x3 → credit=200, no reject.
   - Key 0x1 → reject_pulse, credit stays 200.
   - Key 0xE → 40 change_pulse cycles.
4. Insufficient credit:
   - Credit 25, key 0x4 → deny_pulse, credit=25, no vend_pulse.
   - Key 0xF → no pulse at all.
5. Sold out:
   - Three funded vends of item 0 → sold_out[0]=1.
   - Fourth attempt with credit 50 → deny_pulse, credit stays 50.
6. Busy and reset mid-change:
   - Cancel at credit 35 → 7 change_pulses.
   - Key 0x3 during CHANGE → ignored; the total refund is still 35.
   - Repeat, and assert reset after the 3rd pulse → change_pulse stops at once and credit=0.
